// File: rtl/bht_setassoc.sv
// Set-associative branch target buffer with saturating direction counters,
// per-set round-robin replacement, EXE-time resolve/allocate, bulk clear and
// a saturating mispredict counter.
module bht_setassoc #(
  parameter int unsigned PC_W     = 12,
  parameter int unsigned SET_BITS = 4,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned PERF_W   = 16
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic [PC_W-1:0]   if_PC,
  output logic              if_prediction,
  output logic [PC_W-1:0]   if_PBT,
  input  logic              exe_valid,
  input  logic [PC_W-1:0]   exe_PC,
  input  logic              exe_is_jump,
  input  logic              exe_is_compressed,
  input  logic              exe_taken,
  input  logic [PC_W-1:0]   exe_target,
  input  logic              exe_pred_taken,
  input  logic [PC_W-1:0]   exe_PBT,
  output logic              exe_mispredict,
  output logic [PC_W-1:0]   exe_CNI,
  input  logic              bht_clear,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned TAG_W = PC_W - SET_BITS - 1;
  localparam int unsigned RR_W  = $clog2(WAYS);

  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
  logic [PC_W-1:0]   tgt_q   [SETS][WAYS];
  logic [PC_W-1:0]   tgt_d   [SETS][WAYS];
  logic [CNT_W-1:0]  cnt_q   [SETS][WAYS];
  logic [CNT_W-1:0]  cnt_d   [SETS][WAYS];
  logic [RR_W-1:0]   rr_q    [SETS];
  logic [RR_W-1:0]   rr_d    [SETS];
  logic [PERF_W-1:0] perf_q, perf_d;

  logic [SET_BITS-1:0] if_set, exe_set;
  logic [TAG_W-1:0]    if_tag, exe_tag;
  logic                if_hit;
  logic                exe_hit, inv_found, taken_eff;
  logic [RR_W-1:0]     exe_way, inv_way, victim;
  logic [PC_W-1:0]     fall;
  logic                unused_pc_bit;

  assign if_set  = if_PC[SET_BITS:1];
  assign if_tag  = if_PC[PC_W-1:SET_BITS+1];
  assign exe_set = exe_PC[SET_BITS:1];
  assign exe_tag = exe_PC[PC_W-1:SET_BITS+1];
  assign unused_pc_bit = if_PC[0];
  assign perf_mispredicts = perf_q;

  // Fetch lookup from registered state; lowest matching way wins.
  always_comb begin
    if_hit        = 1'b0;
    if_prediction = 1'b0;
    if_PBT        = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!if_hit && valid_q[if_set][w] && (tag_q[if_set][w] == if_tag)) begin
        if_hit        = 1'b1;
        if_prediction = cnt_q[if_set][w][CNT_W-1];
        if_PBT        = tgt_q[if_set][w];
      end
    end
  end

  // EXE resolve: correct next address and mispredict detection.
  always_comb begin
    taken_eff      = exe_taken | exe_is_jump;
    fall           = exe_PC + (exe_is_compressed ? PC_W'(2) : PC_W'(4));
    exe_CNI        = '0;
    exe_mispredict = 1'b0;
    if (exe_valid) begin
      exe_CNI        = taken_eff ? exe_target : fall;
      exe_mispredict = (taken_eff != exe_pred_taken) ||
                       (taken_eff && (exe_target != exe_PBT));
    end
  end

  // EXE-side way search: hit way and lowest invalid way of the resolved set.
  always_comb begin
    exe_hit   = 1'b0;
    exe_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!exe_hit && valid_q[exe_set][w] && (tag_q[exe_set][w] == exe_tag)) begin
        exe_hit = 1'b1;
        exe_way = RR_W'(w);
      end
      if (!inv_found && !valid_q[exe_set][w]) begin
        inv_found = 1'b1;
        inv_way   = RR_W'(w);
      end
    end
    victim = inv_found ? inv_way : rr_q[exe_set];
  end

  // Next-state for table, replacement pointers and mispredict counter.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    perf_d  = perf_q;
    if (exe_mispredict && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
    if (bht_clear) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_d[s] = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_d[s][w] = 1'b0;
        end
      end
    end else if (exe_valid) begin
      if (exe_hit) begin
        if (taken_eff) begin
          tgt_d[exe_set][exe_way] = exe_target;
          if (cnt_q[exe_set][exe_way] != '1) begin
            cnt_d[exe_set][exe_way] = cnt_q[exe_set][exe_way] + CNT_W'(1);
          end
        end else if (cnt_q[exe_set][exe_way] != '0) begin
          cnt_d[exe_set][exe_way] = cnt_q[exe_set][exe_way] - CNT_W'(1);
        end
      end else if (taken_eff) begin
        valid_d[exe_set][victim] = 1'b1;
        tag_d[exe_set][victim]   = exe_tag;
        tgt_d[exe_set][victim]   = exe_target;
        cnt_d[exe_set][victim]   = exe_is_jump ? '1 : CNT_W'(1 << (CNT_W - 1));
        if (!inv_found) begin
          rr_d[exe_set] = rr_q[exe_set] + RR_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      perf_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          cnt_q[s][w]   <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      perf_q  <= perf_d;
    end
  end

endmodule
